// File: rtl/interrupt_pkg.sv
// interrupt_pkg
// Shared definitions for the interrupt sequencer and every other user of the
// flag register: request count, flag field positions and the sequencer state
// encoding.
package interrupt_pkg;

  localparam int IRQ_COUNT = 9;

  // Flag register field positions; all flag consumers index through these.
  localparam int FLAG_COMPARE_LSB = 0;
  localparam int FLAG_COMPARE_MSB = 2;
  localparam int FLAG_IRQ_LSB     = 3;
  localparam int FLAG_IRQ_MSB     = 11;
  localparam int FLAG_PAGE_LSB    = 12;
  localparam int FLAG_PAGE_MSB    = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_VECTOR  = 3'd2,
    ST_ISR     = 3'd3,
    ST_RESTORE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder
// Combinational fixed-priority encoder: the lowest set bit of eligible wins.
// Ports:
//   eligible  in   IRQ_COUNT  enabled pending requests
//   index     out  4          index of the winning request (0 when none)
//   valid     out  1          at least one request is eligible
module irq_priority_encoder
  import interrupt_pkg::*;
(
  input  logic [IRQ_COUNT-1:0] eligible,
  output logic [3:0]           index,
  output logic                 valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = 4'd0;
    valid = 1'b0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        index = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Latches rising edges on the external request lines, masks them with the
// flag register enables and, at an instruction boundary, runs the interrupt
// entry (backup accumulator, save PC, load vector). On reti it runs the
// return (restore accumulator, reload PC from the return-address register).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   irq_lines                  external requests, rising-edge sensitive
//   flag_input                 flag register; [11:3] are per-request enables
//   pc_input                   address of the next instruction
//   return_address_input       saved return address from Register_File
//   instr_boundary, reti       control unit handshakes
//   r_backup, r_restore        accumulator save/restore strobes
//   return_address_write/data  return-address register write port
//   pc_write, pc_data          PC load port
//   stall                      holds the control unit in sequencer cycles
//   in_isr                     handler active
//   pending                    latched request bits
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter logic [15:0] VECTOR_STRIDE = 16'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_COUNT-1:0] irq_lines,
  input  logic [15:0]          flag_input,
  input  logic [15:0]          pc_input,
  input  logic [15:0]          return_address_input,
  input  logic                 instr_boundary,
  input  logic                 reti,
  output logic                 r_backup,
  output logic                 r_restore,
  output logic                 return_address_write,
  output logic [15:0]          return_address_data,
  output logic                 pc_write,
  output logic [15:0]          pc_data,
  output logic                 stall,
  output logic                 in_isr,
  output logic [IRQ_COUNT-1:0] pending
);

  seq_state_t           state_q, state_d;
  logic [IRQ_COUNT-1:0] pending_q, pending_d;
  logic [IRQ_COUNT-1:0] irq_prev_q, irq_prev_d;
  logic [3:0]           sel_q, sel_d;

  logic [IRQ_COUNT-1:0] eligible;
  logic [IRQ_COUNT-1:0] clear_mask;
  logic [3:0]           take_index;
  logic                 take_valid;
  logic                 unused_flag_bits;

  assign eligible = pending_q & flag_input[FLAG_IRQ_MSB:FLAG_IRQ_LSB];
  assign unused_flag_bits = ^{flag_input[FLAG_PAGE_MSB:FLAG_PAGE_LSB],
                              flag_input[FLAG_COMPARE_MSB:FLAG_COMPARE_LSB]};

  irq_priority_encoder u_priority (
    .eligible (eligible),
    .index    (take_index),
    .valid    (take_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      irq_prev_q <= '0;
      sel_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      irq_prev_q <= irq_prev_d;
      sel_q      <= sel_d;
    end
  end

  // Edge capture and acknowledge. The clear is applied before the set so a
  // fresh edge on the serviced line during VECTOR keeps it pending.
  always_comb begin
    irq_prev_d = irq_lines;
    clear_mask = '0;
    if (state_q == ST_VECTOR) begin
      clear_mask = IRQ_COUNT'(1) << sel_q;
    end
    pending_d = (pending_q & ~clear_mask) | (irq_lines & ~irq_prev_q);
  end

  // Next-state logic; the winning index is frozen on the take so later
  // changes to pending or enables cannot redirect the sequence.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_boundary && take_valid) begin
          state_d = ST_SAVE;
          sel_d   = take_index;
        end
      end
      ST_SAVE:    state_d = ST_VECTOR;
      ST_VECTOR:  state_d = ST_ISR;
      ST_ISR: begin
        if (reti) begin
          state_d = ST_RESTORE;
        end
      end
      ST_RESTORE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    r_backup             = 1'b0;
    r_restore            = 1'b0;
    return_address_write = 1'b0;
    return_address_data  = 16'h0000;
    pc_write             = 1'b0;
    pc_data              = 16'h0000;
    stall                = 1'b0;
    in_isr               = 1'b0;
    unique case (state_q)
      ST_SAVE: begin
        r_backup             = 1'b1;
        return_address_write = 1'b1;
        return_address_data  = pc_input;
        stall                = 1'b1;
      end
      ST_VECTOR: begin
        pc_write = 1'b1;
        pc_data  = VECTOR_BASE + ({12'h000, sel_q} * VECTOR_STRIDE);
        stall    = 1'b1;
      end
      ST_ISR: begin
        in_isr = 1'b1;
      end
      ST_RESTORE: begin
        r_restore = 1'b1;
        pc_write  = 1'b1;
        pc_data   = return_address_input;
        stall     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign pending = pending_q;

endmodule
